// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and ALU op encoding used by the issue stage and the ALU.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decode: selects op and operands, flags anything else illegal.
module alu_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output dec_t        dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    alu_op_e    op;
    logic [31:0] a;
    logic [31:0] b;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        unique case (opc)
            OPC_OP: begin
                legal = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000: op = ALU_ADD;
                        3'b001: op = ALU_SLL;
                        3'b100: op = ALU_XOR;
                        3'b101: op = ALU_SRL;
                        3'b110: op = ALU_OR;
                        3'b111: op = ALU_AND;
                        default: legal = 1'b0;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
                if (legal) begin
                    a = rs1_data_i;
                    b = rs2_data_i;
                end
            end
            OPC_OP_IMM: begin
                legal = 1'b1;
                b     = {{20{instr_i[31]}}, instr_i[31:20]};
                case (f3)
                    3'b000: op = ALU_ADD;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        op    = ALU_SLL;
                        legal = (f7 == F7_BASE);
                        b     = {27'b0, instr_i[24:20]};
                    end
                    3'b101: begin
                        op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        b     = {27'b0, instr_i[24:20]};
                    end
                    default: legal = 1'b0;
                endcase
                a = rs1_data_i;
                // Illegal encodings must present a clean ADD 0,0.
                if (!legal) begin
                    op = ALU_ADD;
                    a  = '0;
                    b  = '0;
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                b     = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a     = pc_i;
                b     = {instr_i[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    assign dec_o = '{op: op, a: a, b: b, rd: instr_i[11:7],
                     rd_we: legal && (instr_i[11:7] != 5'd0), illegal: !legal};

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode in front of a 2-entry skid buffer (output reg + skid reg).
module alu_issue_stage
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [2:0]  alu_op_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    dec_t dec;
    dec_t out_q, out_d, skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic accept, drain;

    alu_decode u_dec (
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .dec_o      (dec)
    );

    assign accept = in_valid_i && in_ready_q;
    assign drain  = out_valid_q && out_ready_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // Skid entry is older than anything accepted now, so it goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign alu_op_o    = out_q.op;
    assign a_o         = out_q.a;
    assign b_o         = out_q.b;
    assign rd_o        = out_q.rd;
    assign rd_we_o     = out_q.rd_we;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench: decode vector table plus backpressure, flush and reset sequences.
module tb_alu_issue_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  alu_op_o;
    logic [31:0] a_o, b_o;
    logic [4:0]  rd_o;
    logic        rd_we_o, illegal_o;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .alu_op_o   (alu_op_o),
        .a_o        (a_o),
        .b_o        (b_o),
        .rd_o       (rd_o),
        .rd_we_o    (rd_we_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        we, ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic we,
                           input logic ill);
        chk({tag, ".valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, ".op"},    32'(alu_op_o),    32'(op));
        chk({tag, ".a"},     a_o,              a);
        chk({tag, ".b"},     b_o,              b);
        chk({tag, ".rd"},    32'(rd_o),        32'(rd));
        chk({tag, ".we"},    32'(rd_we_o),     32'(we));
        chk({tag, ".ill"},   32'(illegal_o),   32'(ill));
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    vec_t vt[14];
    logic [2:0]  snap_op;
    logic [31:0] snap_a, snap_b;
    logic [4:0]  snap_rd;
    logic        have_snap;

    initial begin
        vt[0]  = '{32'hFFF08293, 0, 32'h10, 0, 3'd0, 32'h10, 32'hFFFFFFFF, 5'd5, 1, 0};
        vt[1]  = '{32'h40415193, 0, 32'h80000000, 0, 3'd7, 32'h80000000, 32'd4, 5'd3, 1, 0};
        vt[2]  = '{32'h003120B3, 0, 32'h11, 32'h22, 3'd0, 0, 0, 5'd1, 0, 1};
        vt[3]  = '{32'h12345037, 0, 32'h99, 0, 3'd0, 0, 32'h12345000, 5'd0, 0, 0};
        vt[4]  = '{32'h00838333, 0, 32'd5, 32'd7, 3'd0, 32'd5, 32'd7, 5'd6, 1, 0};
        vt[5]  = '{32'h40838333, 0, 32'd5, 32'd7, 3'd1, 32'd5, 32'd7, 5'd6, 1, 0};
        vt[6]  = '{32'hABCDE117, 32'h1000, 32'h7, 0, 3'd0, 32'h1000, 32'hABCDE000, 5'd2, 1, 0};
        vt[7]  = '{32'h7F00C213, 0, 32'h55, 0, 3'd4, 32'h55, 32'h7F0, 5'd4, 1, 0};
        vt[8]  = '{32'h41F09493, 0, 32'h3, 0, 3'd0, 0, 0, 5'd9, 0, 1};
        vt[9]  = '{32'h01F09493, 0, 32'h3, 0, 3'd5, 32'h3, 32'd31, 5'd9, 1, 0};
        vt[10] = '{32'h003170B3, 0, 32'hF0, 32'h3C, 3'd2, 32'hF0, 32'h3C, 5'd1, 1, 0};
        vt[11] = '{32'h00002083, 0, 32'h1, 0, 3'd0, 0, 0, 5'd1, 0, 1};
        vt[12] = '{32'h0000B093, 0, 32'h1, 0, 3'd0, 0, 0, 5'd1, 0, 1};
        vt[13] = '{32'h00515093, 0, 32'hA0, 0, 3'd6, 32'hA0, 32'd5, 5'd1, 1, 0};

        rst_i = 1'b1; flush_i = 0; in_valid_i = 0; out_ready_i = 1;
        instr_i = 0; pc_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        #12;
        chk("rst.valid", 32'(out_valid_o), 0);
        chk("rst.ready", 32'(in_ready_o), 1);
        chk("rst.op", 32'(alu_op_o), 0);
        chk("rst.a", a_o, 0);
        chk("rst.b", b_o, 0);
        chk("rst.rd", 32'(rd_o), 0);
        chk("rst.we_ill", 32'({rd_we_o, illegal_o}), 0);
        @(negedge clk_i); rst_i = 0;
        @(posedge clk_i); #1;

        // Decode table, one instruction per cycle with the sink always ready.
        for (int i = 0; i < 14; i++) begin
            in_valid_i = 1; instr_i = vt[i].instr; pc_i = vt[i].pc;
            rs1_data_i = vt[i].rs1; rs2_data_i = vt[i].rs2;
            @(posedge clk_i); #1;
            chk_out($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].rd,
                    vt[i].we, vt[i].ill);
        end
        in_valid_i = 0;
        @(posedge clk_i); #1;
        chk("idle.valid", 32'(out_valid_o), 0);

        // Backpressure: 4 ADDIs, sink stalled for the first 3 cycles.
        begin
            int sent = 0, recv = 0;
            logic fi, fo;
            have_snap = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                out_ready_i = (cyc >= 3);
                in_valid_i  = (sent < 4);
                instr_i     = addi(sent + 1);
                rs1_data_i  = 32'h100 * (sent + 1);
                fi = in_valid_i && in_ready_o;
                fo = out_valid_o && out_ready_i;
                if (fo) begin
                    chk($sformatf("bp.rd%0d", recv), 32'(rd_o), 32'(recv + 1));
                    chk($sformatf("bp.b%0d", recv), b_o, 32'(recv + 1));
                    chk($sformatf("bp.a%0d", recv), a_o, 32'h100 * (recv + 1));
                    recv++;
                end
                if (out_valid_o && !out_ready_i) begin
                    if (have_snap) begin
                        chk("bp.stable", {alu_op_o, rd_o, a_o[23:0]}, {snap_op, snap_rd, snap_a[23:0]});
                        chk("bp.stable_b", b_o, snap_b);
                    end
                    snap_op = alu_op_o; snap_a = a_o; snap_b = b_o; snap_rd = rd_o;
                    have_snap = 1;
                end
                @(posedge clk_i); #1;
                if (fi) begin
                    sent++;
                    if (sent == 2) chk("bp.ready_drop", 32'(in_ready_o), 0);
                end
            end
            chk("bp.recv_count", 32'(recv), 4);
            chk("bp.drained", 32'(out_valid_o), 0);
        end

        // Flush with both entries full and input offered.
        out_ready_i = 0; in_valid_i = 1;
        instr_i = addi(10); @(posedge clk_i); #1;
        instr_i = addi(11); @(posedge clk_i); #1;
        chk("fl.full", 32'({out_valid_o, in_ready_o}), 32'b10);
        flush_i = 1; instr_i = addi(12);
        @(posedge clk_i); #1;
        flush_i = 0; in_valid_i = 0;
        chk("fl.valid", 32'(out_valid_o), 0);
        chk("fl.ready", 32'(in_ready_o), 1);
        // Flush with one entry held and an input that does get accepted.
        in_valid_i = 1; instr_i = addi(13); @(posedge clk_i); #1;
        flush_i = 1; instr_i = addi(14); @(posedge clk_i); #1;
        flush_i = 0; in_valid_i = 0; out_ready_i = 1;
        chk("fl2.valid", 32'(out_valid_o), 0);
        chk("fl2.ready", 32'(in_ready_o), 1);
        @(posedge clk_i); #1;
        chk("fl2.no_ghost", 32'(out_valid_o), 0);

        // Async reset mid-stall.
        out_ready_i = 0; in_valid_i = 1;
        instr_i = addi(20); rs1_data_i = 32'h5; @(posedge clk_i); #1;
        instr_i = addi(21); @(posedge clk_i); #1;
        in_valid_i = 0;
        #2 rst_i = 1; #1;
        chk("ar.valid", 32'(out_valid_o), 0);
        chk("ar.ready", 32'(in_ready_o), 1);
        chk("ar.data", {alu_op_o, rd_o, rd_we_o, illegal_o}, 0);
        chk("ar.ab", a_o | b_o, 0);
        @(negedge clk_i); rst_i = 0;
        @(posedge clk_i); #1;
        out_ready_i = 1; in_valid_i = 1; instr_i = 32'hFFF08293; rs1_data_i = 32'h10;
        @(posedge clk_i); #1;
        in_valid_i = 0;
        chk_out("ar.addi", 3'd0, 32'h10, 32'hFFFFFFFF, 5'd5, 1, 0);
        @(posedge clk_i); #1;
        chk("ar.single", 32'(out_valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have ports `clk_i`, input, 1: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have `rst_i`, input, 1: reset, asynchronous, active-high.
REQ-003 The block SHALL have `flush_i`, input, 1: synchronous discard of all held entries.
REQ-004 The block SHALL have `in_valid_i` (input, 1) and `in_ready_o` (output, 1): upstream handshake.
REQ-005 The block SHALL have `instr_i`, input, 32: RV32I instruction word.
REQ-006 The block SHALL have `pc_i`, `rs1_data_i` and `rs2_data_i`, each input, 32: PC and register operands.
REQ-007 The block SHALL have `out_valid_o` (output, 1) and `out_ready_i` (input, 1): downstream handshake.
REQ-008 The block SHALL have `alu_op_o`, output, 3: ALU operation code.
REQ-009 The block SHALL have `a_o` and `b_o`, each output, 32: ALU operands.
REQ-010 The block SHALL have `rd_o` (output, 5), `rd_we_o` (output, 1) and `illegal_o` (output, 1).

Function
REQ-011 The ALU op encoding SHALL be: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SRA 111.
REQ-012 OP (0110011) decoding SHALL be:
- funct7 0000000: funct3 000 ADD, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND.
- funct7 0100000: funct3 000 SUB, 101 SRA.
- operands: a=rs1_data_i, b=rs2_data_i.
REQ-013 OP-IMM (0010011) decoding SHALL be:
- funct3 000/100/110/111 map to ADD/XOR/OR/AND, with b=sign-extended instr[31:20].
- funct3 001 SHALL require instr[31:25]=0 (SLL).
- funct3 101 SHALL require instr[31:25]=0000000 (SRL) or 0100000 (SRA).
- shifts: b={27'b0, instr[24:20]}.
- a=rs1_data_i in all cases.
REQ-014 LUI (0110111) SHALL produce ADD, a=0, b={instr[31:12],12'b0}; AUIPC (0010111) SHALL produce ADD, a=pc_i, b={instr[31:12],12'b0}.
REQ-015 The following SHALL set illegal_o=1, rd_we_o=0, alu_op_o=ADD, a_o=b_o=0:
- all other opcodes;
- SLT, SLTU, SLTI, SLTIU;
- non-matching funct7/imm[11:5].
REQ-016 rd_o SHALL equal instr[11:7]; rd_we_o SHALL be 1 only for legal instructions with rd≠0.
REQ-017 A transfer SHALL occur when in_valid_i && in_ready_o; decoded results SHALL appear at the outputs with out_valid_o=1 on the following cycle when the output stage is empty or draining (latency 1).
REQ-018 Storage SHALL be a 2-entry skid buffer (output register + skid register); in_ready_o SHALL be a registered signal equal to "skid entry empty".
REQ-019 While out_valid_o && !out_ready_i, all outputs SHALL hold stable; an input accepted during this stall SHALL go to the skid entry and in_ready_o SHALL drop the next cycle.
REQ-020 When the output drains with the skid entry full, the skid entry SHALL move to the output register and in_ready_o SHALL rise the next cycle.
REQ-021 Order SHALL be preserved, with no loss or duplication under any valid/ready pattern; simultaneous output drain and input accept with an empty skid SHALL load the output register directly.
REQ-022 flush_i SHALL clear both entries at the next edge: out_valid_o=0, in_ready_o=1. An input accepted in the flush cycle SHALL be dropped. Flush SHALL take priority over all handshakes.

Reset
REQ-023 On rst_i high, asynchronously:
- out_valid_o=0, in_ready_o=1;
- alu_op_o=000, a_o=b_o=0, rd_o=0;
- rd_we_o=0, illegal_o=0;
- skid entry invalid.
REQ-024 Reset asserted mid-stall SHALL discard both entries; the first accept after deassertion SHALL behave as from empty.

Structure
REQ-025 The ALU op codes, RV32I opcode constants (OP, OP_IMM, LUI, AUIPC) and funct7 constants SHALL live in shared package `rv32i_pkg`, also used by the ALU.
REQ-026 Decode SHALL be combinational in sub-module `alu_decode` (instr, pc, rs1, rs2 -> op, a, b, rd, rd_we, illegal); the top SHALL contain only the skid buffer.

Verification
REQ-027 ADDI x5,x1,-1 (0xFFF08293), rs1_data=0x10, out_ready_i=1 -> next cycle: out_valid_o=1, alu_op_o=000, a_o=0x10, b_o=0xFFFFFFFF, rd_o=5, rd_we_o=1.
REQ-028 SRAI x3,x2,4 (0x40415193), rs1_data=0x80000000 -> alu_op_o=111, a_o=0x80000000, b_o=4, rd_o=3; SLT x1,x2,x3 (0x003120B3) -> illegal_o=1, rd_we_o=0.
REQ-029 LUI x0,0x12345 (0x12345037) -> alu_op_o=000, a_o=0, b_o=0x12345000, rd_we_o=0, illegal_o=0.
REQ-030 Backpressure test:
- stimulus: in_valid_i held high with 4 distinct instructions; out_ready_i low for 3 cycles, then high.
- response: in_ready_o drops after the second accept; all 4 instructions emerge in order exactly once; outputs stable during the stall.
REQ-031 Flush test:
- stimulus: both entries full, then flush_i=1 for one cycle with in_valid_i=1.
- response: next cycle out_valid_o=0 and in_ready_o=1; the flushed-cycle input never appears.
REQ-032 Reset test: assert rst_i asynchronously mid-stall -> outputs immediately at REQ-023 values; after release, a new ADDI SHALL emerge with latency 1.
